// File: rtl/console_pkg.sv
// Shared constants and state type for the text console front end.
package console_pkg;

   localparam logic [7:0]  CC_BS     = 8'h08;
   localparam logic [7:0]  CC_LF     = 8'h0A;
   localparam logic [7:0]  CC_FF     = 8'h0C;
   localparam logic [7:0]  CC_CR     = 8'h0D;
   localparam logic [7:0]  CH_SPACE  = 8'h20;
   localparam logic [7:0]  CH_TILDE  = 8'h7E;
   localparam logic [11:0] TEXT_BASE = 12'h400;

   typedef enum logic [1:0] {
      StClearAll,
      StIdle,
      StWrite,
      StClearRow
   } state_e;

endpackage

// File: rtl/text_console.sv
// Byte-stream to text-buffer bus master: tracks a cursor, prints printable bytes,
// interprets CR/LF/BS/FF and blanks rows as the screen wraps.
module text_console
   import console_pkg::*;
#(
   parameter int unsigned  COLS = 32,
   parameter int unsigned  ROWS = 30,
   parameter logic [11:0]  BASE = TEXT_BASE,
   localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [11:0]   addr,
   output logic [7:0]    data,
   output logic          rw,
   output logic          busy,
   output logic [CW-1:0] cur_col,
   output logic [RW-1:0] cur_row
);

   localparam int unsigned   CELLS    = ROWS * COLS;
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   state_e        state_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [10:0]   cnt_q;
   logic          pend_q;
   logic [11:0]   addr_q;
   logic [7:0]    data_q;
   logic          rw_q;
   logic          ready_q;
   logic          busy_q;

   function automatic logic [11:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      logic [31:0] a;
      a = 32'(BASE) + 32'(r) * COLS + 32'(c);
      return a[11:0];
   endfunction

   function automatic logic [11:0] lin_addr(input logic [10:0] idx);
      logic [31:0] a;
      a = 32'(BASE) + 32'(idx);
      return a[11:0];
   endfunction

   function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
      return (r == ROW_LAST) ? '0 : r + RW'(1);
   endfunction

   // Each transition emits the bus cycle for the following clock, so clears
   // issued from IDLE or WRITE start with their first cell already on the bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StClearAll;
         col_q   <= '0;
         row_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         addr_q  <= BASE;
         data_q  <= CH_SPACE;
         rw_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         rw_q <= 1'b0;
         unique case (state_q)
            StClearAll: begin
               if (32'(cnt_q) < CELLS) begin
                  rw_q   <= 1'b1;
                  addr_q <= lin_addr(cnt_q);
                  data_q <= CH_SPACE;
                  cnt_q  <= cnt_q + 11'd1;
               end else begin
                  state_q <= StIdle;
                  col_q   <= '0;
                  row_q   <= '0;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            StIdle: begin
               if (in_valid) begin
                  if (in_data >= CH_SPACE && in_data <= CH_TILDE) begin
                     rw_q    <= 1'b1;
                     addr_q  <= cell_addr(row_q, col_q);
                     data_q  <= in_data;
                     state_q <= StWrite;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     if (col_q == COL_LAST) begin
                        col_q  <= '0;
                        row_q  <= row_inc(row_q);
                        pend_q <= 1'b1;
                     end else begin
                        col_q  <= col_q + CW'(1);
                        pend_q <= 1'b0;
                     end
                  end else begin
                     case (in_data)
                        CC_CR: col_q <= '0;
                        CC_LF: begin
                           col_q   <= '0;
                           row_q   <= row_inc(row_q);
                           rw_q    <= 1'b1;
                           addr_q  <= cell_addr(row_inc(row_q), '0);
                           data_q  <= CH_SPACE;
                           cnt_q   <= 11'd1;
                           state_q <= StClearRow;
                           ready_q <= 1'b0;
                           busy_q  <= 1'b1;
                        end
                        CC_BS: begin
                           if (col_q != '0) begin
                              col_q   <= col_q - CW'(1);
                              rw_q    <= 1'b1;
                              addr_q  <= cell_addr(row_q, col_q - CW'(1));
                              data_q  <= CH_SPACE;
                              pend_q  <= 1'b0;
                              state_q <= StWrite;
                              ready_q <= 1'b0;
                              busy_q  <= 1'b1;
                           end
                        end
                        CC_FF: begin
                           col_q   <= '0;
                           row_q   <= '0;
                           rw_q    <= 1'b1;
                           addr_q  <= BASE;
                           data_q  <= CH_SPACE;
                           cnt_q   <= 11'd1;
                           state_q <= StClearAll;
                           ready_q <= 1'b0;
                           busy_q  <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            StWrite: begin
               if (pend_q) begin
                  pend_q  <= 1'b0;
                  rw_q    <= 1'b1;
                  addr_q  <= cell_addr(row_q, '0);
                  data_q  <= CH_SPACE;
                  cnt_q   <= 11'd1;
                  state_q <= StClearRow;
               end else begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            StClearRow: begin
               if (32'(cnt_q) < COLS) begin
                  rw_q   <= 1'b1;
                  addr_q <= cell_addr(row_q, CW'(cnt_q));
                  data_q <= CH_SPACE;
                  cnt_q  <= cnt_q + 11'd1;
               end else begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StClearAll;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign in_ready = ready_q;
   assign addr     = addr_q;
   assign data     = data_q;
   assign rw       = rw_q;
   assign busy     = busy_q;
   assign cur_col  = col_q;
   assign cur_row  = row_q;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed scenarios plus random byte
// streams compared against a cursor/screen reference model.
module tb_text_console;
   import console_pkg::*;

   localparam int          COLS  = 32;
   localparam int          ROWS  = 30;
   localparam int          CELLS = ROWS * COLS;
   localparam logic [11:0] BASE  = 12'h400;

   typedef struct {
      int          cyc;
      logic [11:0] a;
      logic [7:0]  d;
      logic        rdy;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] addr;
   logic [7:0]  data;
   logic        rw;
   logic        busy;
   logic [4:0]  cur_col;
   logic [4:0]  cur_row;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   wr_t         got_q[$];
   wr_t         exp_q[$];
   logic [7:0]  mscr[CELLS];
   logic [7:0]  dscr[CELLS];
   int          m_row = 0;
   int          m_col = 0;
   int          n_got;
   logic [11:0] first_a;
   logic [11:0] last_a;

   text_console #(.COLS(COLS), .ROWS(ROWS), .BASE(BASE)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .addr     (addr),
      .data     (data),
      .rw       (rw),
      .busy     (busy),
      .cur_col  (cur_col),
      .cur_row  (cur_row)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rw === 1'b1) begin
         got_q.push_back('{cyc, addr, data, in_ready});
         if (int'(addr) >= int'(BASE) && int'(addr) - int'(BASE) < CELLS)
            dscr[int'(addr) - int'(BASE)] = data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_cur(input string tag, input int r, input int c);
      check({tag, "/row"}, 32'(cur_row), r);
      check({tag, "/col"}, 32'(cur_col), c);
   endtask

   // Reference model: cursor as integers, screen as an array, expected writes as a list.
   task automatic mwrite(input int idx, input logic [7:0] d);
      exp_q.push_back('{0, 12'(int'(BASE) + idx), d, 1'b0});
      mscr[idx] = d;
   endtask

   task automatic mblank_row(input int r);
      for (int c = 0; c < COLS; c++) mwrite(r * COLS + c, CH_SPACE);
   endtask

   task automatic model_clear_all();
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      for (int i = 0; i < CELLS; i++) mwrite(i, CH_SPACE);
   endtask

   function automatic bit printable(input logic [7:0] b);
      return b >= 8'h20 && b <= 8'h7E;
   endfunction

   task automatic model(input logic [7:0] b);
      exp_q.delete();
      if (printable(b)) begin
         mwrite(m_row * COLS + m_col, b);
         m_col++;
         if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
            mblank_row(m_row);
         end
      end else if (b == CC_CR) begin
         m_col = 0;
      end else if (b == CC_LF) begin
         m_col = 0;
         m_row = (m_row + 1) % ROWS;
         mblank_row(m_row);
      end else if (b == CC_BS) begin
         if (m_col > 0) begin
            m_col--;
            mwrite(m_row * COLS + m_col, CH_SPACE);
         end
      end else if (b == CC_FF) begin
         model_clear_all();
      end
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (in_ready !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "/ready"}, 32'(in_ready), 1);
   endtask

   task automatic cmp_writes(input string tag);
      int bad = 0;
      n_got = got_q.size();
      first_a = (n_got > 0) ? got_q[0].a : 12'hxxx;
      last_a = (n_got > 0) ? got_q[n_got-1].a : 12'hxxx;
      check({tag, "/nwrites"}, n_got, exp_q.size());
      if (exp_q.size() > 0 && n_got == exp_q.size()) begin
         foreach (exp_q[i]) begin
            if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) bad++;
            if (got_q[i].cyc != got_q[0].cyc + i) bad++;
            if (got_q[i].rdy !== 1'b0) bad++;
         end
         check({tag, "/write_errs"}, bad, 0);
      end
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      int acc;
      model(b);
      got_q.delete();
      in_data = b;
      in_valid = 1'b1;
      wait_ready({tag, "/pre"});
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (b != CC_FF) check_cur({tag, "/accept"}, m_row, m_col);
      if (printable(b)) begin
         check({tag, "/rw_n1"}, 32'(rw), 1);
         check({tag, "/addr_n1"}, 32'(addr), 32'(exp_q[0].a));
         check({tag, "/data_n1"}, 32'(data), 32'(b));
         check({tag, "/rdy_n1"}, 32'(in_ready), 0);
      end
      // in_valid stays high while busy; it must not be consumed again
      wait_ready({tag, "/post"});
      in_valid = 1'b0;
      in_data = 8'($urandom);
      cmp_writes(tag);
      if (printable(b) && n_got > 0) check({tag, "/wr_cycle"}, got_q[0].cyc, acc);
      check_cur({tag, "/final"}, m_row, m_col);
      check({tag, "/busy"}, 32'(busy), 0);
   endtask

   task automatic release_and_clear(input string tag);
      model_clear_all();
      got_q.delete();
      reset = 1'b1;
      @(negedge clk);
      check({tag, "/first_rw"}, 32'(rw), 1);
      check({tag, "/first_addr"}, 32'(addr), 32'h400);
      wait_ready(tag);
      cmp_writes(tag);
      check({tag, "/first"}, 32'(first_a), 32'h400);
      check({tag, "/last"}, 32'(last_a), 32'h7BF);
      check_cur({tag, "/cur"}, 0, 0);
   endtask

   initial begin
      logic [7:0] b;
      int r;

      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst/addr", 32'(addr), 32'h400);
      check("rst/data", 32'(data), 32'h20);
      check("rst/rw", 32'(rw), 0);
      check("rst/in_ready", 32'(in_ready), 0);
      check("rst/busy", 32'(busy), 1);
      check_cur("rst", 0, 0);
      release_and_clear("init_clear");

      send(8'h41, "A");
      check("A/addr", 32'(first_a), 32'h400);
      send(8'h42, "B");
      check("B/addr", 32'(first_a), 32'h401);
      check_cur("AB", 0, 2);

      send(CC_CR, "cr0");
      for (int i = 0; i < COLS; i++) send(8'($urandom_range(33, 126)), "row_fill");
      check("wrap/n", n_got, 33);
      check("wrap/first", 32'(first_a), 32'h41F);
      check("wrap/last", 32'(last_a), 32'h43F);
      check_cur("wrap", 1, 0);

      for (int i = 0; i < 28; i++) send(CC_LF, "lf_walk");
      for (int i = 0; i < 5; i++) send(8'h2E, "dots");
      check_cur("at_29_5", 29, 5);
      send(CC_LF, "lf_wrap");
      check("lf_wrap/n", n_got, 32);
      check("lf_wrap/first", 32'(first_a), 32'h400);
      check("lf_wrap/last", 32'(last_a), 32'h41F);
      check_cur("lf_wrap", 0, 0);

      for (int i = 0; i < 3; i++) send(CC_LF, "lf3");
      for (int i = 0; i < 7; i++) send(8'h78, "x7");
      send(CC_CR, "cr");
      check("cr/n", n_got, 0);
      check_cur("cr", 3, 0);

      for (int i = 0; i < 29; i++) send(CC_LF, "lf29");
      for (int i = 0; i < 4; i++) send(8'h79, "y4");
      send(CC_BS, "bs");
      check("bs/n", n_got, 1);
      check("bs/addr", 32'(first_a), 32'h443);
      check_cur("bs", 2, 3);
      send(CC_CR, "cr2");
      send(CC_BS, "bs_col0");
      check("bs_col0/n", n_got, 0);
      send(8'h07, "bell");
      check("bell/n", n_got, 0);

      send(CC_FF, "ff");
      check("ff/n", n_got, CELLS);
      check("ff/first", 32'(first_a), 32'h400);
      check("ff/last", 32'(last_a), 32'h7BF);

      // reset in the middle of a form-feed clear
      model(CC_FF);
      in_data = CC_FF;
      in_valid = 1'b1;
      wait_ready("ff_rst/pre");
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (479) @(negedge clk);
      check("ff_rst/mid_rw", 32'(rw), 1);
      #2 reset = 1'b0;
      #1;
      check("ff_rst/rw_async", 32'(rw), 0);
      check("ff_rst/busy", 32'(busy), 1);
      check("ff_rst/in_ready", 32'(in_ready), 0);
      check("ff_rst/addr", 32'(addr), 32'h400);
      repeat (2) @(negedge clk);
      release_and_clear("restart");

      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         r = $urandom_range(0, 99);
         if (r < 68) b = 8'($urandom_range(32, 126));
         else if (r < 78) b = CC_LF;
         else if (r < 88) b = CC_BS;
         else if (r < 93) b = CC_CR;
         else if (r < 94) b = CC_FF;
         else if (r % 2 == 1) b = 8'($urandom_range(127, 255));
         else b = 8'($urandom_range(0, 7));
         send(b, "rand");
      end

      r = 0;
      for (int i = 0; i < CELLS; i++) if (mscr[i] !== dscr[i]) r++;
      check("screen_image", r, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console.md
# text_console

Character-stream front end for the text video buffer. It accepts a stream of ASCII bytes over a valid/ready handshake, tracks a cursor, and turns each byte into single-cycle write transactions on the memory-mapped bus that feeds `textbuffer`. It interprets a small set of control codes: CR, LF, BS and FF. It replaces the free-running test `counter` as the bus master in the `0x4xx` text window.

## Interface

Parameters:
- `COLS`, default 32: characters per row.
- `ROWS`, default 30: rows on screen. `ROWS*COLS` must be ≤ 1024.
- `BASE`, default 12'h400: bus address of cell (row 0, col 0).

Ports:
- `clk` in 1: system clock (PLL output).
- `reset` in 1: asynchronous, active-low.
- `in_data` in 8: byte to print or interpret.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `addr` out 12: bus address.
- `data` out 8: bus write data.
- `rw` out 1: 1 means write `data` to `addr` this cycle (drives `tb_we` via the decoder); 0 means idle bus.
- `busy` out 1: a clear or write sequence is in progress.
- `cur_col` out `$clog2(COLS)`: cursor column.
- `cur_row` out `$clog2(ROWS)`: cursor row.

## Operation

- The cell address for (r, c) is `BASE + r*COLS + c`, truncated to 12 bits.
- A transfer occurs on a rising edge with `in_valid && in_ready`. `in_ready` is 1 only in IDLE.
- States:
  - CLEAR_ALL: writes 0x20 to every cell in ascending order. Takes `ROWS*COLS` cycles with `rw`=1. Ends with the cursor at (0,0), then goes to IDLE.
  - IDLE: `rw`=0, `in_ready`=1, `busy`=0.
  - WRITE: one cycle. Performs `rw`=1 at the latched address with the latched data. Then goes to IDLE, or to CLEAR_ROW if the cursor moved to a new row.
  - CLEAR_ROW: writes 0x20 to the `COLS` cells of the new `cur_row` (col 0 upward), then goes to IDLE.
- Byte handling on accept:
  - 0x20–0x7E: WRITE the byte at the cursor, then advance `col`. If `col` was `COLS-1`, set `col`=0 and `row`=row+1, wrapping `ROWS-1` to 0, and CLEAR_ROW the new row.
  - 0x0D (CR): `col`=0. No bus activity. Stays in IDLE.
  - 0x0A (LF): `col`=0, `row`=row+1 (wraps), then CLEAR_ROW.
  - 0x08 (BS):
    - If `col`>0: `col`=col−1, then WRITE 0x20 at the new position.
    - If `col`=0: no change and no write.
  - 0x0C (FF): goes to CLEAR_ALL.
  - All other bytes are consumed and ignored, with no bus activity.
- Scrolling is ring-style. There is no readback or copy; the screen wraps to row 0 and the new row is blanked.

## Timing

- Reset values, held while `reset`=0:
  - `addr`=`BASE`, `data`=0x20, `rw`=0
  - `in_ready`=0, `busy`=1
  - cursor (0,0)
  - state CLEAR_ALL
- First edge after reset release: `rw`=1, `addr`=`BASE`. The last clear write is at `BASE+ROWS*COLS-1`. The following cycle has `in_ready`=1.
- All outputs are registered.
- Printable byte accepted at edge N:
  - cycle N+1: `rw`=1, `addr`/`data` = old cursor address and the byte; `in_ready`=0.
  - cycle N+2: IDLE again (`in_ready`=1), or the first CLEAR_ROW write.
- Cursor outputs update at the accept edge.
- CLEAR_ROW takes exactly `COLS` consecutive `rw` cycles. CLEAR_ALL takes exactly `ROWS*COLS`.
- An `in_valid` held while `in_ready`=0 is not consumed. The source must hold `in_data` stable.
- Reset asserted mid-sequence: `rw` drops to 0 asynchronously and the sequence restarts with CLEAR_ALL.
- `busy` = (state ≠ IDLE).

## Structure

- Shared package `console_pkg` holds:
  - control-code constants: `CC_BS`=8'h08, `CC_LF`=8'h0A, `CC_FF`=8'h0C, `CC_CR`=8'h0D, `CH_SPACE`=8'h20
  - the state enum: CLEAR_ALL, IDLE, WRITE, CLEAR_ROW
  - the text bus window base 12'h400
- Single module with no sub-module. Cell-address computation is a local function.
- The chip top instantiates `text_console` in place of `counter`. Its `addr`/`data`/`rw` drive the existing `casex` decoder.

## Test plan

- Reset release → exactly 960 consecutive writes, `addr` 0x400…0x7BF, `data` 0x20. Then `in_ready`=1 and cursor (0,0).
- Send 'A' (0x41) then 'B' → writes (0x400, 0x41) and (0x401, 0x42), each one cycle after accept. Cursor ends at (0,2).
- Send 32 printable bytes from (0,0) → last write at 0x41F. Next come 32 writes of 0x20 at 0x420…0x43F, and the cursor is (1,0).
- Cursor at (29,5), send LF → 32 writes of 0x20 at 0x400…0x41F. Cursor is (0,0). CR at (3,7) → no writes, cursor (3,0).
- BS at (2,4) → one write (0x443, 0x20), cursor (2,3). BS at (2,0) → no write. Byte 0x07 → consumed, no write.
- FF mid-screen → 960 clear writes with `in_ready`=0 throughout. Asserting `reset` halfway through a clear → `rw`=0 immediately, then a full 960-write clear restarts after release.
